// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned BYTE_CNT_W     = 2;

endpackage

// File: rtl/imem_loader_byte_assembler.sv
// Big-endian byte-to-word assembler: the word is presented combinationally
// together with the byte that completes it, so the writer can latch it that cycle.
module byte_assembler
    import imem_loader_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        clr,
    input  logic        take,
    input  logic [7:0]  din,
    output logic [31:0] word,
    output logic        full
);

    logic [23:0]           sr_q, sr_d;
    logic [BYTE_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (clr) begin
            sr_d  = '0;
            cnt_d = '0;
        end else if (take) begin
            sr_d  = {sr_q[15:0], din};
            cnt_d = cnt_q + BYTE_CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

    // Only three bytes are stored; the fourth is the incoming byte itself.
    assign word = {sr_q, din};
    assign full = take & (cnt_q == BYTE_CNT_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Program loader: streams bytes into 32-bit words, writes them to consecutive
// instruction-memory addresses and holds the CPU in reset while doing so.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic [ADDR_W:0]   NWORDS,
    input  logic              BYTE_VALID,
    input  logic [7:0]        BYTE_DATA,
    output logic              BYTE_READY,
    output logic              WE,
    output logic [ADDR_W-1:0] W_Addr,
    output logic [31:0]       W_Ins,
    output logic              CPU_RST,
    output logic              BUSY,
    output logic              DONE
);

    localparam logic [ADDR_W:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};

    state_t            state_q, state_d;
    logic [ADDR_W:0]   nwords_q, nwords_d;
    logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] w_addr_q, w_addr_d;
    logic [31:0]       w_ins_q, w_ins_d;
    logic              cpu_rst_q, cpu_rst_d;
    logic              done_q, done_d;

    logic        take;
    logic        word_full;
    logic [31:0] asm_word;

    assign take = (state_q == S_RECV) & BYTE_VALID;

    byte_assembler u_asm (
        .CLK  (CLK),
        .RST  (RST),
        .clr  (state_q == S_IDLE),
        .take (take),
        .din  (BYTE_DATA),
        .word (asm_word),
        .full (word_full)
    );

    always_comb begin
        state_d    = state_q;
        nwords_d   = nwords_q;
        word_cnt_d = word_cnt_q;
        we_d       = 1'b0;
        w_addr_d   = w_addr_q;
        w_ins_d    = w_ins_q;
        done_d     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (START) begin
                    nwords_d   = (NWORDS > MAX_WORDS) ? MAX_WORDS : NWORDS;
                    word_cnt_d = '0;
                    if (NWORDS == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_RECV;
                    end
                end
            end
            S_RECV: begin
                if (word_full) begin
                    w_ins_d  = asm_word;
                    w_addr_d = BASE_ADDR + word_cnt_q[ADDR_W-1:0];
                    we_d     = 1'b1;
                    state_d  = S_WRITE;
                end
            end
            S_WRITE: begin
                word_cnt_d = word_cnt_q + {{ADDR_W{1'b0}}, 1'b1};
                if (word_cnt_d == nwords_q) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_RECV;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // CPU reset follows the next state, so it falls on the first IDLE cycle.
        cpu_rst_d = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            nwords_q   <= '0;
            word_cnt_q <= '0;
            we_q       <= 1'b0;
            w_addr_q   <= BASE_ADDR;
            w_ins_q    <= '0;
            cpu_rst_q  <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            nwords_q   <= nwords_d;
            word_cnt_q <= word_cnt_d;
            we_q       <= we_d;
            w_addr_q   <= w_addr_d;
            w_ins_q    <= w_ins_d;
            cpu_rst_q  <= cpu_rst_d;
            done_q     <= done_d;
        end
    end

    assign BYTE_READY = (state_q == S_RECV);
    assign BUSY       = (state_q != S_IDLE);
    assign WE         = we_q;
    assign W_Addr     = w_addr_q;
    assign W_Ins      = w_ins_q;
    assign CPU_RST    = cpu_rst_q;
    assign DONE       = done_q;

endmodule
